// File: rtl/descriptor_addr_prefetcher.sv
// rtl/descriptor_addr_prefetcher.sv - free descriptor address prefetch FIFO with flush return path
// Optional debug counters are compiled in with DESCRIPTOR_PREFETCH_STATS_EN.
module descriptor_addr_prefetcher #(
  parameter int DESCRIPTOR_MEM_ADDR_WIDTH = 1,
  parameter int DEPTH                     = 4,
  parameter int LOW_WATERMARK             = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] free_descriptor_addr_i,
  input  logic                                 free_descriptor_addr_valid_i,
  output logic                                 ack_descriptor_addr_o,
  output logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] alloc_addr_o,
  output logic                                 alloc_valid_o,
  input  logic                                 alloc_ready_i,
  input  logic                                 flush_i,
  output logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] free_addr_o,
  output logic                                 free_valid_o,
  input  logic                                 free_ack_i,
  output logic [$clog2(DEPTH):0]               count_o,
  output logic                                 level_low_o,
  output logic                                 flushing_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] LOW_LEVEL  = CW'(LOW_WATERMARK);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e                               state_q, state_d;
  logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]                        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                        count_q, count_d;
  logic                                 ack_q, ack_d;
  logic                                 level_low_q, level_low_d;
  logic                                 flushing_q, flushing_d;
  logic                                 ack;
  logic                                 pop;

  // ack_q blocks the manager's stale valid in the cycle right after an ack
  assign ack = free_descriptor_addr_valid_i && (state_q == ST_RUN) &&
               (count_q < FULL_LEVEL) && !ack_q && !flush_i;

  assign alloc_valid_o = (count_q != '0) && (state_q == ST_RUN);
  assign free_valid_o  = (count_q != '0) && (state_q == ST_FLUSH);
  assign pop = (alloc_valid_o && alloc_ready_i) || (free_valid_o && free_ack_i);

  assign ack_descriptor_addr_o = ack;
  assign alloc_addr_o          = mem_q[rd_ptr_q];
  assign free_addr_o           = mem_q[rd_ptr_q];
  assign count_o               = count_q;
  assign level_low_o           = level_low_q;
  assign flushing_o            = flushing_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (ack) begin
      mem_d[wr_ptr_q] = free_descriptor_addr_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({ack, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      ST_RUN:   if (flush_i) state_d = ST_FLUSH;
      ST_FLUSH: if (count_d == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    ack_d       = ack;
    flushing_d  = (state_d == ST_FLUSH);
    level_low_d = (count_d <= LOW_LEVEL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_RUN;
      ack_q       <= 1'b0;
      level_low_q <= 1'b1;
      flushing_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      ack_q       <= ack_d;
      level_low_q <= level_low_d;
      flushing_q  <= flushing_d;
    end
  end

`ifdef DESCRIPTOR_PREFETCH_STATS_EN
  logic [31:0] num_prefetched_q, num_prefetched_d;
  logic [31:0] num_returned_q, num_returned_d;
  logic [31:0] num_starved_q, num_starved_d;

  always_comb begin
    num_prefetched_d = num_prefetched_q + {31'd0, ack};
    num_returned_d   = num_returned_q + {31'd0, free_valid_o && free_ack_i};
    num_starved_d    = num_starved_q +
                       {31'd0, alloc_ready_i && !alloc_valid_o && (state_q == ST_RUN)};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      num_prefetched_q <= '0;
      num_returned_q   <= '0;
      num_starved_q    <= '0;
    end else begin
      num_prefetched_q <= num_prefetched_d;
      num_returned_q   <= num_returned_d;
      num_starved_q    <= num_starved_d;
    end
  end
`else
`endif

endmodule

// File: tb/tb_descriptor_addr_prefetcher.sv
// tb/tb_descriptor_addr_prefetcher.sv - scoreboard bench for descriptor_addr_prefetcher
// Reference model tracks FIFO contents as a queue and occupancy as an integer.
module tb_descriptor_addr_prefetcher;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int LW    = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  addr_i;
  logic          valid_i;
  logic          ack_o;
  logic [W-1:0]  alloc_addr_o;
  logic          alloc_valid_o;
  logic          alloc_ready_i;
  logic          flush_i;
  logic [W-1:0]  free_addr_o;
  logic          free_valid_o;
  logic          free_ack_i;
  logic [CW-1:0] count_o;
  logic          level_low_o;
  logic          flushing_o;

  descriptor_addr_prefetcher #(
    .DESCRIPTOR_MEM_ADDR_WIDTH(W),
    .DEPTH(DEPTH),
    .LOW_WATERMARK(LW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .free_descriptor_addr_i(addr_i),
    .free_descriptor_addr_valid_i(valid_i),
    .ack_descriptor_addr_o(ack_o),
    .alloc_addr_o(alloc_addr_o),
    .alloc_valid_o(alloc_valid_o),
    .alloc_ready_i(alloc_ready_i),
    .flush_i(flush_i),
    .free_addr_o(free_addr_o),
    .free_valid_o(free_valid_o),
    .free_ack_i(free_ack_i),
    .count_o(count_o),
    .level_low_o(level_low_o),
    .flushing_o(flushing_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [W-1:0] exp_q[$];
  int m_count;
  bit m_flush;
  bit m_prev_ack;
  bit acked;
  int m_prefetched, m_returned, m_starved;

  // Reference model: evaluated mid-cycle once inputs are stable
  always @(negedge clk) begin : model
    bit e_ack, e_av, e_fv, e_pop;
    if (rst) begin
      m_count = 0; m_flush = 0; m_prev_ack = 0; acked = 0;
      m_prefetched = 0; m_returned = 0; m_starved = 0;
      exp_q.delete();
    end else begin
      e_ack = valid_i && !m_flush && (m_count < DEPTH) && !m_prev_ack && !flush_i;
      e_av  = (m_count != 0) && !m_flush;
      e_fv  = (m_count != 0) && m_flush;
      chk("ack", {31'd0, ack_o}, {31'd0, e_ack});
      chk("alloc_valid", {31'd0, alloc_valid_o}, {31'd0, e_av});
      chk("free_valid", {31'd0, free_valid_o}, {31'd0, e_fv});
      chk("count", 32'(count_o), 32'(m_count));
      chk("level_low", {31'd0, level_low_o}, {31'd0, m_count <= LW});
      chk("flushing", {31'd0, flushing_o}, {31'd0, m_flush});
      e_pop = (e_av && alloc_ready_i) || (e_fv && free_ack_i);
      if (e_ack) exp_q.push_back(addr_i);
      m_count = m_count + int'(e_ack) - int'(e_pop);
      if (!m_flush) m_flush = flush_i;
      else if (m_count == 0) m_flush = 0;
      m_prefetched += int'(e_ack);
      m_returned   += int'(e_fv && free_ack_i);
      m_starved    += int'(alloc_ready_i && !e_av && !m_flush);
      m_prev_ack = e_ack;
      acked = e_ack;
    end
  end

  always @(negedge clk) begin : monitor
    if (!rst) begin
      if (alloc_valid_o === 1'b1 && alloc_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL alloc_pop: got pop of %0h expected no entry at %0t", alloc_addr_o, $time);
        end else chk("alloc_addr", 32'(alloc_addr_o), 32'(exp_q.pop_front()));
      end
      if (free_valid_o === 1'b1 && free_ack_i) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL free_pop: got return of %0h expected no entry at %0t", free_addr_o, $time);
        end else chk("free_addr", 32'(free_addr_o), 32'(exp_q.pop_front()));
      end
    end
  end

  logic [W-1:0] next_addr;
  bit hold_addr;

  // Manager model: moves on to a new address once the previous one is taken
  task automatic cycle();
    @(posedge clk);
    #1;
    if (acked && !hold_addr) next_addr++;
    addr_i = next_addr;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alloc_valid"}, {31'd0, alloc_valid_o}, 32'd0);
    chk({tag, "_free_valid"}, {31'd0, free_valid_o}, 32'd0);
    chk({tag, "_flushing"}, {31'd0, flushing_o}, 32'd0);
    chk({tag, "_level_low"}, {31'd0, level_low_o}, 32'd1);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
    chk({tag, "_ack"}, {31'd0, ack_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; alloc_ready_i = 1'b0; flush_i = 1'b0; free_ack_i = 1'b0;
    hold_addr = 1'b0; next_addr = 8'h10; addr_i = next_addr;
    #7;
    chk_reset_outputs("reset");
    cycle();
    rst = 1'b0;

    // Fill to full with the manager offering continuously
    valid_i = 1'b1;
    repeat (10) cycle();
    chk("fill_count", 32'(count_o), 32'd4);
    chk("fill_head", 32'(alloc_addr_o), 32'h10);
    chk("fill_offer_held", 32'(addr_i), 32'h14);

    // Back-to-back pops while refilling, then drain
    alloc_ready_i = 1'b1;
    repeat (8) cycle();
    valid_i = 1'b0;
    repeat (6) cycle();
    chk("drain_count", 32'(count_o), 32'd0);

    // Stale valid the cycle after an ack must not duplicate the entry
    alloc_ready_i = 1'b0; hold_addr = 1'b1; valid_i = 1'b1;
    repeat (2) cycle();
    valid_i = 1'b0;
    repeat (2) cycle();
    chk("holdoff_count", 32'(count_o), 32'd1);
    hold_addr = 1'b0; next_addr++; addr_i = next_addr;
    alloc_ready_i = 1'b1;
    repeat (3) cycle();

    // Flush three entries, returned every other cycle
    alloc_ready_i = 1'b0; next_addr = 8'h21; addr_i = next_addr; valid_i = 1'b1;
    for (int k = 0; k < 20 && count_o != 3; k++) cycle();
    chk("flush_prefill", 32'(count_o), 32'd3);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0; alloc_ready_i = 1'b1;
    chk("flush_enter", {31'd0, flushing_o}, 32'd1);
    chk("flush_head", 32'(free_addr_o), 32'h21);
    for (int i = 0; i < 6; i++) begin
      free_ack_i = (i % 2 == 0);
      cycle();
    end
    free_ack_i = 1'b0;
    chk("flush_exit", {31'd0, flushing_o}, 32'd0);
    valid_i = 1'b0;
    repeat (4) cycle();

    // Empty flush lasts exactly one cycle
    alloc_ready_i = 1'b0; flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    chk("empty_flush_enter", {31'd0, flushing_o}, 32'd1);
    cycle();
    chk("empty_flush_exit", {31'd0, flushing_o}, 32'd0);

    // Randomized traffic
    repeat (3000) begin
      valid_i       = ($urandom_range(0, 3) != 0);
      alloc_ready_i = $urandom_range(0, 1) == 1;
      flush_i       = ($urandom_range(0, 24) == 0);
      free_ack_i    = $urandom_range(0, 1) == 1;
      cycle();
    end

    // Asynchronous reset in the middle of a flush
    valid_i = 1'b1; alloc_ready_i = 1'b0; flush_i = 1'b0; free_ack_i = 1'b0;
    repeat (10) cycle();
    valid_i = 1'b0; flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    chk("pre_reset_free_valid", {31'd0, free_valid_o}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_reset");
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_reset_count", 32'(count_o), 32'd0);

`ifdef DESCRIPTOR_PREFETCH_STATS_EN
    chk("stat_prefetched", dut.num_prefetched_q, 32'(m_prefetched));
    chk("stat_returned", dut.num_returned_q, 32'(m_returned));
    chk("stat_starved", dut.num_starved_q, 32'(m_starved));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
